// File: rtl/ramio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ramio_pkg
//  Description : Shared types, address map and helpers for the ramio
//                memory/IO target: read/write access encodings, IO register
//                addresses, region decode type, read-data formatting and the
//                misalignment test used when RAMIO_ALIGN_FAULT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package ramio_pkg;

    // read_type[1:0] selects the size and read_type[2] requests sign extension.
    typedef enum logic [2:0] {
        RdNone  = 3'b000,
        RdByteU = 3'b001,
        RdHalfU = 3'b010,
        RdWordU = 3'b011,
        RdByteS = 3'b101,
        RdHalfS = 3'b110,
        RdWordS = 3'b111
    } read_type_e;

    typedef enum logic [1:0] {
        WrNone = 2'b00,
        WrByte = 2'b01,
        WrHalf = 2'b10,
        WrWord = 2'b11
    } write_type_e;

    // Decoded target of the current address.
    typedef enum logic [1:0] {
        SelRam  = 2'b00,
        SelUart = 2'b01,
        SelLed  = 2'b10,
        SelNone = 2'b11
    } region_e;

    localparam logic [31:0] AddrUart = 32'hFFFF_FFF8;
    localparam logic [31:0] AddrLed  = 32'hFFFF_FFFC;

    // Extract the addressed lane from a RAM/IO word and extend it to 32 bits.
    // A size code of 0 yields 0, which also gives data_out its reset value.
    function automatic logic [31:0] format_read(input logic [31:0] word,
                                                input logic [2:0]  rtype,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (rtype[1:0])
            2'b01:   r = {{24{rtype[2] & b[7]}}, b};
            2'b10:   r = {{16{rtype[2] & h[15]}}, h};
            2'b11:   r = word;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Half accesses must be 2-byte aligned, word accesses 4-byte aligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lo);
        logic m;
        case (size)
            2'b10:   m = lo[0];
            2'b11:   m = (lo != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ramio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ramio_uart_tx
//  Description : 8N1 serial transmitter. One start bit (0), eight data bits
//                LSB first, one stop bit (1); every bit lasts BitTicks clocks.
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset (aborts a frame)
//                go     - accept data and start a frame (honoured when
//                         active is low)
//                data   - byte to send
//                active - frame in progress; drops on the last stop-bit
//                         cycle so a queued byte can start without a gap
//                tx     - serial line, idles high
//  Revision    : 1.0 - initial release
// ============================================================================
module ramio_uart_tx #(
    parameter int BitTicks = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [7:0] data,
    output logic       active,
    output logic       tx
);

    localparam int c_tick_w = (BitTicks > 1) ? $clog2(BitTicks) : 1;
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(BitTicks - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StStart = 2'b01,
        StData  = 2'b10,
        StStop  = 2'b11
    } tx_state_e;

    tx_state_e           r_state, w_state_nx;
    logic [c_tick_w-1:0] r_tick,  w_tick_nx;
    logic [2:0]          r_bit,   w_bit_nx;
    logic [7:0]          r_shift, w_shift_nx;
    logic                w_tick_done;

    assign w_tick_done = (r_tick == c_tick_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_tick  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            r_state <= w_state_nx;
            r_tick  <= w_tick_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_tick_nx  = w_tick_done ? '0 : r_tick + 1'b1;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        active     = 1'b1;
        tx         = 1'b1;
        case (r_state)
            StIdle: begin
                active    = 1'b0;
                w_tick_nx = '0;
                if (go) begin
                    w_state_nx = StStart;
                    w_shift_nx = data;
                end
            end
            StStart: begin
                tx = 1'b0;
                if (w_tick_done) begin
                    w_state_nx = StData;
                    w_bit_nx   = 3'd0;
                end
            end
            StData: begin
                tx = r_shift[0];
                if (w_tick_done) begin
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    w_bit_nx   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nx = StStop;
                    end
                end
            end
            StStop: begin
                // Final stop-bit cycle: report idle so the next byte can be
                // committed on this edge and its start bit follows directly.
                if (w_tick_done) begin
                    active = 1'b0;
                    if (go) begin
                        w_state_nx = StStart;
                        w_shift_nx = data;
                    end else begin
                        w_state_nx = StIdle;
                    end
                end
            end
            default: w_state_nx = StIdle;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ramio.sv
`default_nettype none
// ============================================================================
//  Module      : ramio
//  Description : Memory/IO target for the core's ramio request interface.
//                Byte-enabled word RAM, 4-bit active-low LED register and an
//                8N1 UART transmitter. Performs read lane extraction with
//                sign/zero extension and write lane placement.
//  Ports       : clk, rst_n (async, active-low)
//                enable, read_type[2:0], write_type[1:0], address[31:0],
//                data_in[31:0]                       - request
//                data_out[31:0], data_out_ready, busy  - response/handshake
//                led[3:0] (active-low), uart_tx, fault - pins / status
//  Options     : RAMIO_ALIGN_FAULT_EN - misaligned half/word accesses set a
//                sticky fault, writes are dropped and reads return 0.
//                Undefined: low address bits are ignored and fault is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module ramio
    import ramio_pkg::*;
#(
    parameter int RamAddressBitWidth = 16,
    parameter int ClockFrequencyHz   = 27_000_000,
    parameter int BaudRate           = 115_200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [2:0]  read_type,
    input  logic [1:0]  write_type,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_out_ready,
    output logic        busy,
    output logic [3:0]  led,
    output logic        uart_tx,
    output logic        fault
);

    localparam int c_bit_ticks = ClockFrequencyHz / BaudRate;
    localparam int c_ram_words = 2 ** (RamAddressBitWidth - 2);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    region_e                       w_region;
    logic [1:0]                    w_size;
    logic                          w_wr_req;
    logic                          w_commit;
    logic                          w_wr_ok;
    logic                          w_rd_latch;
    logic                          w_misalign;
    logic                          w_tx_active;
    logic                          w_ram_we;
    logic                          w_uart_go;
    logic [3:0]                    w_be;
    logic [31:0]                   w_wdata;
    logic [31:0]                   w_io_rd;
    logic [RamAddressBitWidth-3:0] w_ram_idx;

    always_comb begin
        w_region = SelNone;
        if (address[31:RamAddressBitWidth] == '0) begin
            w_region = SelRam;
        end else if (address == AddrUart) begin
            w_region = SelUart;
        end else if (address == AddrLed) begin
            w_region = SelLed;
        end
    end

    // A request with both types set is a write, so the write size wins.
    assign w_size     = (write_type != WrNone) ? write_type : read_type[1:0];
    assign w_wr_req   = enable && (write_type != WrNone);
    assign busy       = w_wr_req && (w_region == SelUart) && w_tx_active;
    assign w_commit   = w_wr_req && !busy;
    assign w_rd_latch = enable && (read_type != RdNone) && (write_type == WrNone);

`ifdef RAMIO_ALIGN_FAULT_EN
    assign w_misalign = is_misaligned(w_size, address[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // A misaligned write still completes the handshake but changes nothing.
    assign w_wr_ok   = w_commit && !w_misalign;
    assign w_ram_we  = w_wr_ok && (w_region == SelRam);
    assign w_uart_go = w_wr_ok && (w_region == SelUart);
    assign w_ram_idx = address[RamAddressBitWidth-1:2];

    // Replicating the source across all lanes lets the byte enables alone
    // pick the destination lane.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = data_in;
        case (write_type)
            WrByte: begin
                w_be    = 4'b0001 << address[1:0];
                w_wdata = {4{data_in[7:0]}};
            end
            WrHalf: begin
                w_be    = address[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{data_in[15:0]}};
            end
            WrWord: begin
                w_be    = 4'b1111;
                w_wdata = data_in;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = data_in;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Block RAM (no reset, so it maps onto a RAM macro)
    // ------------------------------------------------------------------
    logic [31:0] r_mem [c_ram_words];
    logic [31:0] r_ram_q;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_ram_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
        // Only capture on a read latch so data_out stays stable afterwards.
        if (w_rd_latch && (w_region == SelRam)) begin
            r_ram_q <= r_mem[w_ram_idx];
        end
    end

    // ------------------------------------------------------------------
    // IO registers
    // ------------------------------------------------------------------
    logic [3:0] r_led;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 4'h0;
        end else if (w_wr_ok && (w_region == SelLed)) begin
            r_led <= data_in[3:0];
        end
    end

    assign led = ~r_led;

    always_comb begin
        case (w_region)
            SelUart: w_io_rd = {31'b0, w_tx_active};
            SelLed:  w_io_rd = {28'b0, r_led};
            default: w_io_rd = 32'h0;
        endcase
    end

    ramio_uart_tx #(
        .BitTicks (c_bit_ticks)
    ) u_uart_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (w_uart_go),
        .data   (data_in[7:0]),
        .active (w_tx_active),
        .tx     (uart_tx)
    );

    // ------------------------------------------------------------------
    // Read latch and response
    // ------------------------------------------------------------------
    logic        r_lat_valid;
    logic [31:0] r_lat_addr;
    logic [2:0]  r_lat_rt;
    region_e     r_lat_sel;
    logic        r_lat_zero;
    logic [31:0] r_io_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_valid <= 1'b0;
            r_lat_addr  <= 32'h0;
            r_lat_rt    <= RdNone;
            r_lat_sel   <= SelNone;
            r_lat_zero  <= 1'b0;
            r_io_q      <= 32'h0;
        end else if (w_rd_latch) begin
            r_lat_valid <= 1'b1;
            r_lat_addr  <= address;
            r_lat_rt    <= read_type;
            r_lat_sel   <= w_region;
            r_lat_zero  <= w_misalign;
            r_io_q      <= w_io_rd;
        end else if (!enable || w_commit) begin
            r_lat_valid <= 1'b0;
        end
    end

    logic [31:0] w_rd_word;

    always_comb begin
        w_rd_word = (r_lat_sel == SelRam) ? r_ram_q : r_io_q;
        if (r_lat_zero) begin
            w_rd_word = 32'h0;
        end
    end

    // Format from the latched type, so an unlatched block reads as 0.
    assign data_out = format_read(w_rd_word, r_lat_rt, r_lat_addr[1:0]);

    // Combinational compare: a changed request drops ready in the same cycle.
    assign data_out_ready = enable && r_lat_valid && (address == r_lat_addr)
                            && (read_type == r_lat_rt) && (read_type != RdNone);

    // ------------------------------------------------------------------
    // Alignment fault
    // ------------------------------------------------------------------
`ifdef RAMIO_ALIGN_FAULT_EN
    logic r_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if ((w_rd_latch || w_commit) && w_misalign) begin
            r_fault <= 1'b1;
        end
    end

    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

endmodule
`default_nettype wire
